muxn_stream: RTL and testbench

- Parametrised N-channel, W-bit stream multiplexer; successor of the 4:1 single-bit combinational mux in the MIPS datapath library.
- Merges N valid/ready producers into one registered consumer port, for example to merge multiple memory or interrupt request sources.
- Two modes, selectable at run time:
  - Explicit select: channel chosen by `sel`.
  - Round-robin: fair arbitration across requesting channels.
- Single output register stage; counts completed transfers.

---
 rtl/muxn_pkg.sv | 34 +++
 rtl/muxn_rr_arbiter.sv | 30 +++
 rtl/muxn_stream.sv | 131 +++++++++++++
 tb/tb_muxn_stream.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared types and the round-robin search used by the stream mux and,
// later, the interrupt controller.
package muxn_pkg;

  typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_t;

  localparam int MAX_N  = 16;
  localparam int MAX_SW = 4;

  typedef struct packed {
    logic              found;
    logic [MAX_SW-1:0] idx;
  } rr_pick_t;

  // Search n channels starting just after 'last', wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]  valid,
                                       input logic [MAX_SW-1:0] last,
                                       input int                n);
    rr_pick_t r;
    int c;
    r = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      if (k <= n) begin
        c = (int'(last) + k) % n;
        if (!r.found && valid[c]) begin
          r.found = 1'b1;
          r.idx   = MAX_SW'(c);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/muxn_rr_arbiter.sv
// Purely combinational round-robin arbiter: one-hot grant plus its index.
module muxn_rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx
);
  import muxn_pkg::*;

  logic [MAX_N-1:0]  validExt;
  logic [MAX_SW-1:0] lastExt;
  rr_pick_t          pick;

  always_comb begin
    validExt          = '0;
    validExt[N-1:0]   = valid;
    lastExt           = '0;
    lastExt[SW-1:0]   = last;
    pick              = rr_pick(validExt, lastExt, N);
    idx               = SW'(pick.idx);
    grant             = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = pick.found && (int'(pick.idx) == i);
    end
  end

endmodule

// File: rtl/muxn_stream.sv
// N-channel valid/ready stream mux with one output register stage and a
// transfer counter. Optional even-parity output under MUXN_STREAM_PARITY_EN.
module muxn_stream #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 16,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready,
  output logic            sel_err,
  output logic [CW-1:0]   xfer_count
`ifdef MUXN_STREAM_PARITY_EN
  ,
  output logic            out_par
`endif
);
  import muxn_pkg::*;

  logic [N-1:0]  rrGrant;
  logic [SW-1:0] rrIdx;
  logic [N-1:0]  grant;
  logic [SW-1:0] grantIdx;
  logic [W-1:0]  grantData;
  logic          selInRange;
  logic          load;

  logic          outValid_q, outValid_d;
  logic [W-1:0]  outData_q,  outData_d;
  logic [SW-1:0] outCh_q,    outCh_d;
  logic [SW-1:0] rrLast_q,   rrLast_d;
  logic [CW-1:0] xferCount_q, xferCount_d;
  logic          selErr_q,   selErr_d;

  muxn_rr_arbiter #(.N(N), .SW(SW)) uArb (
    .valid (in_valid),
    .last  (rrLast_q),
    .grant (rrGrant),
    .idx   (rrIdx)
  );

  always_comb begin
    selInRange = int'(sel) < N;
    grant      = '0;
    grantIdx   = '0;
    if (mux_mode_t'(mode) == MODE_RR) begin
      grant    = rrGrant;
      grantIdx = rrIdx;
    end else if (selInRange) begin
      for (int i = 0; i < N; i++) begin
        grant[i] = in_valid[i] && (int'(sel) == i);
      end
      grantIdx = sel;
    end
    grantData = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grantData = in_data[i*W +: W];
    end
  end

  // The register may refill in the same cycle it drains; reset blocks handshakes.
  assign load     = !outValid_q || out_ready;
  assign in_ready = grant & {N{load && !reset}};

  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    outCh_d     = outCh_q;
    rrLast_d    = rrLast_q;
    if (load) begin
      if (|grant) begin
        outValid_d = 1'b1;
        outData_d  = grantData;
        outCh_d    = grantIdx;
        rrLast_d   = grantIdx;
      end else begin
        outValid_d = 1'b0;
      end
    end
    xferCount_d = xferCount_q + CW'(outValid_q && out_ready);
    selErr_d    = (mux_mode_t'(mode) == MODE_SEL) && !selInRange;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outCh_q     <= '0;
      rrLast_q    <= SW'(N - 1);
      xferCount_q <= '0;
      selErr_q    <= 1'b0;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      outCh_q     <= outCh_d;
      rrLast_q    <= rrLast_d;
      xferCount_q <= xferCount_d;
      selErr_q    <= selErr_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign out_ch     = outCh_q;
  assign sel_err    = selErr_q;
  assign xfer_count = xferCount_q;

`ifdef MUXN_STREAM_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^outData_d;
    end
  end

  assign out_par = par_q;
`endif

endmodule

// File: tb/tb_muxn_stream.sv
// Bench for muxn_stream: reference model for the N=4 instance plus directed
// checks on an N=5, CW=4 instance.
module tb_muxn_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        reset, mode, outReady;
  logic [1:0]  sel;
  logic [3:0]  inValid, inReady;
  logic [31:0] inData;
  logic        outValid, selErr;
  logic [7:0]  outData;
  logic [1:0]  outCh;
  logic [15:0] xferCount;

  logic        bReset, bMode, bOutReady;
  logic [2:0]  bSel;
  logic [4:0]  bValid, bReady;
  logic [39:0] bData;
  logic        bOutValid, bSelErr;
  logic [7:0]  bOutData;
  logic [2:0]  bOutCh;
  logic [3:0]  bCount;
`ifdef MUXN_STREAM_PARITY_EN
  logic        outPar, bPar;
`endif

  muxn_stream #(.N(4), .W(8), .CW(16)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_valid(inValid), .in_data(inData), .in_ready(inReady),
    .out_valid(outValid), .out_data(outData), .out_ch(outCh),
    .out_ready(outReady), .sel_err(selErr), .xfer_count(xferCount)
`ifdef MUXN_STREAM_PARITY_EN
    , .out_par(outPar)
`endif
  );

  muxn_stream #(.N(5), .W(8), .CW(4)) dut5 (
    .clk(clk), .reset(bReset), .mode(bMode), .sel(bSel),
    .in_valid(bValid), .in_data(bData), .in_ready(bReady),
    .out_valid(bOutValid), .out_data(bOutData), .out_ch(bOutCh),
    .out_ready(bOutReady), .sel_err(bSelErr), .xfer_count(bCount)
`ifdef MUXN_STREAM_PARITY_EN
    , .out_par(bPar)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model of the 4-channel instance, kept as plain integers.
  int         mValid, mCh, mLast, mCount, mErr;
  logic [7:0] mData;

  function automatic int pickCh();
    int c;
    if (mode == 1'b0) begin
      if (int'(sel) < 4 && inValid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= 4; k++) begin
      c = (mLast + k) % 4;
      if (inValid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (reset) begin
      mValid = 0; mData = 8'h00; mCh = 0; mErr = 0; mCount = 0; mLast = 3;
    end else begin
      g = pickCh();
      mErr = (mode == 1'b0 && int'(sel) >= 4) ? 1 : 0;
      if (mValid == 1 && outReady) mCount = (mCount + 1) % 65536;
      if (mValid == 0 || outReady) begin
        if (g >= 0) begin
          mData  = inData[g*8 +: 8];
          mCh    = g;
          mValid = 1;
          mLast  = g;
        end else begin
          mValid = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] expReady;
    g = pickCh();
    expReady = 4'b0000;
    if (g >= 0 && (mValid == 0 || outReady) && !reset) expReady[g] = 1'b1;
    checkOutput("in_ready",   32'(inReady),   32'(expReady));
    checkOutput("out_valid",  32'(outValid),  32'(mValid));
    checkOutput("out_data",   32'(outData),   32'(mData));
    checkOutput("out_ch",     32'(outCh),     32'(mCh));
    checkOutput("sel_err",    32'(selErr),    32'(mErr));
    checkOutput("xfer_count", 32'(xferCount), 32'(mCount));
`ifdef MUXN_STREAM_PARITY_EN
    checkOutput("out_par",    32'(outPar),    32'(^mData));
`endif
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic m, input logic [1:0] s,
                               input logic [3:0] v, input logic [31:0] d,
                               input logic ordy);
    reset = r; mode = m; sel = s; inValid = v; inData = d; outReady = ordy;
  endtask

  initial begin
    logic [7:0] held;
    applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 32'h44332211, 1'b1);
    bReset = 1'b1; bMode = 1'b0; bSel = 3'd0; bValid = '0; bData = '0; bOutReady = 1'b1;

    repeat (2) stepCycle();
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_count", 32'(xferCount), 32'd0);
    checkOutput("reset_in_ready", 32'(inReady), 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("first_rr_ch", 32'(outCh), 32'd0);
    checkOutput("first_rr_data", 32'(outData), 32'h11);

    applyStimulus(1'b0, 1'b0, 2'd2, 4'b0100,
                  {8'($urandom), 8'hA5, 16'($urandom)}, 1'b1);
    #1 checkOutput("sel_in_ready", 32'(inReady), 32'b0100);
    stepCycle();
    checkOutput("sel_valid", 32'(outValid), 32'd1);
    checkOutput("sel_data", 32'(outData), 32'hA5);
    checkOutput("sel_ch", 32'(outCh), 32'd2);

    applyStimulus(1'b1, 1'b1, 2'd0, 4'h0, 32'h0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 2'd0, 4'hF, $urandom, 1'b1);
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput("rr_seq_ch", 32'(outCh), 32'(i % 4));
    end
    inValid = 4'h0;
    stepCycle();
    checkOutput("rr_count", 32'(xferCount), 32'd8);
    checkOutput("rr_idle_valid", 32'(outValid), 32'd0);

    inValid = 4'hF;
    inData  = $urandom;
    stepCycle();
    checkOutput("bp_first_ch", 32'(outCh), 32'd0);
    held = inData[7:0];
    outReady = 1'b0;
    inData = $urandom;
    repeat (3) begin
      #1 checkOutput("bp_in_ready", 32'(inReady), 32'd0);
      stepCycle();
      checkOutput("bp_data_hold", 32'(outData), 32'(held));
      checkOutput("bp_count_hold", 32'(xferCount), 32'd8);
    end
    outReady = 1'b1;
    #1 checkOutput("bp_release_ready", 32'(inReady), 32'b0010);
    stepCycle();
    checkOutput("bp_refill_valid", 32'(outValid), 32'd1);
    checkOutput("bp_refill_ch", 32'(outCh), 32'd1);
    checkOutput("bp_refill_data", 32'(outData), 32'(inData[15:8]));
    checkOutput("bp_refill_count", 32'(xferCount), 32'd9);
    inValid = 4'h0;

    bData = {$urandom, 8'($urandom)};
    stepCycle();
    bReset = 1'b0; bSel = 3'd1; bValid = 5'h1F;
    stepCycle();
    checkOutput("n5_sel1_valid", 32'(bOutValid), 32'd1);
    checkOutput("n5_sel1_ch", 32'(bOutCh), 32'd1);
    checkOutput("n5_sel1_err", 32'(bSelErr), 32'd0);
    bSel = 3'd6;
    #1 checkOutput("n5_bad_sel_ready", 32'(bReady), 32'd0);
    stepCycle();
    checkOutput("n5_sel_err", 32'(bSelErr), 32'd1);
    checkOutput("n5_bad_sel_drain", 32'(bOutValid), 32'd0);
    bSel = 3'd1;
    stepCycle();
    checkOutput("n5_err_clear", 32'(bSelErr), 32'd0);
    checkOutput("n5_restore_ch", 32'(bOutCh), 32'd1);
    checkOutput("n5_restore_valid", 32'(bOutValid), 32'd1);

    bReset = 1'b1;
    stepCycle();
    bReset = 1'b0; bSel = 3'd0; bData = {$urandom, 8'h07};
    repeat (18) stepCycle();
    checkOutput("n5_count_wrap", 32'(bCount), 32'd1);
    checkOutput("n5_wrap_data", 32'(bOutData), 32'h07);
`ifdef MUXN_STREAM_PARITY_EN
    checkOutput("n5_parity", 32'(bPar), 32'd1);
`endif
    bValid = '0;

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, 1'($urandom), 2'($urandom),
                    4'($urandom), $urandom, $urandom_range(0, 3) != 0);
      stepCycle();
    end
    reset = 1'b0;
    stepCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
